// File: rtl/toaplan2_cen_pkg.sv
// Shared definitions for the Toaplan2 fractional clock-enable bank.
// Latency: n/a (types, constants and an index helper only).
// Backpressure: n/a.
//
// Contents:
//   CEN_W_MAX      widest supported ratio/accumulator width
//   MEAS_W         width of the optional per-channel pulse counter
//   cen_ratio_t    {n, m} ratio pair
//   CEN_IDX        flat bit index of channel ch, stage k in the cen bus
//   R_1350_OF_945  1/7   (e.g. 27 MHz -> 3.857 MHz)
//   R_4_OF_945     8/189 (e.g. 27 MHz -> 1.143 MHz)
package toaplan2_cen_pkg;

    localparam int CEN_W_MAX = 16;
    localparam int MEAS_W    = 16;

    typedef struct packed {
        logic [CEN_W_MAX-1:0] n;
        logic [CEN_W_MAX-1:0] m;
    } cen_ratio_t;

    localparam cen_ratio_t R_1350_OF_945 = '{n: 16'd1, m: 16'd7};
    localparam cen_ratio_t R_4_OF_945    = '{n: 16'd8, m: 16'd189};

    // Stage k of channel ch lives at bit ch*divs+k of the flat cen bus.
    function automatic int CEN_IDX(input int ch, input int k, input int divs = 4);
        return ch * divs + k;
    endfunction

endpackage

// File: rtl/toaplan2_cen_chan.sv
// One fractional clock-enable channel: accumulator, ratio shadow, /2 chain.
// Latency: pulses are registered, one CLK after the accumulator decision.
// Backpressure: none; pause freezes state and silences outputs.
//
// Ports: clk/reset (sync, active-high), pause, sync, we + wr_n/wr_m (shadow
// write), busy (shadow pending), cen[DIVS] (base + /2 stages), cenb
// (half-phase base). With TOAPLAN2_CEN_MEASURE_EN: meas_win, meas_cnt.
module toaplan2_cen_chan
    import toaplan2_cen_pkg::*;
#(
    parameter int             W     = 8,
    parameter int             DIVS  = 4,
    parameter logic [W-1:0]   N_RST = W'(1),
    parameter logic [W-1:0]   M_RST = W'(7)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pause,
    input  logic              sync,
    input  logic              we,
    input  logic [W-1:0]      wr_n,
    input  logic [W-1:0]      wr_m,
    output logic              busy,
    output logic [DIVS-1:0]   cen,
    output logic              cenb
`ifdef TOAPLAN2_CEN_MEASURE_EN
    ,
    input  logic              meas_win,
    output logic [MEAS_W-1:0] meas_cnt
`endif
);

    localparam int DC = (DIVS > 1) ? DIVS - 1 : 1;

    logic [W-1:0]    n_q, m_q, acc_q, sh_n, sh_m;
    logic            busy_q;
    logic [DC-1:0]   div_q;
    logic [DIVS-1:0] cen_q;
    logic            cenb_q;

    logic [W:0]      sum;
    logic [W-1:0]    half, acc_nxt, acc_apl;
    logic            disabled, full, pulse, hit, apply;
    logic [DIVS-1:0] stage;

    always_comb begin
        sum      = {1'b0, acc_q} + {1'b0, n_q};
        half     = m_q >> 1;
        disabled = (m_q == '0);
        // n >= m would let acc run away; treat as "every cycle" with acc pinned.
        full     = !disabled && (n_q >= m_q);
        pulse    = !disabled && (full || (sum >= {1'b0, m_q}));

        if (disabled || full)
            acc_nxt = '0;
        else if (pulse)
            acc_nxt = W'(sum - {1'b0, m_q});
        else
            acc_nxt = W'(sum);

        // acc crosses m/2 this cycle without wrapping: half-phase point.
        hit = !disabled && !pulse && (acc_q < half) && (sum >= {1'b0, half});

        stage = '0;
        for (int k = 0; k < DIVS; k++)
            stage[k] = pulse && ((div_q & DC'((1 << k) - 1)) == '0);

        // Shadow lands on a period boundary so no pulse is stretched or cut.
        apply   = busy_q && (sync || disabled || (pulse && !pause));
        acc_apl = (acc_nxt >= sh_m) ? '0 : acc_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            n_q    <= N_RST;
            m_q    <= M_RST;
            acc_q  <= '0;
            div_q  <= '0;
            sh_n   <= '0;
            sh_m   <= '0;
            busy_q <= 1'b0;
            cen_q  <= '0;
            cenb_q <= 1'b0;
        end else begin
            cen_q  <= '0;
            cenb_q <= 1'b0;
            if (sync) begin
                acc_q <= '0;
                div_q <= '0;
            end else if (!pause) begin
                acc_q  <= apply ? acc_apl : acc_nxt;
                if (pulse)
                    div_q <= div_q + DC'(1);
                cen_q  <= stage;
                cenb_q <= hit;
            end
            if (apply) begin
                n_q    <= sh_n;
                m_q    <= sh_m;
                busy_q <= 1'b0;
            end
            // A write in the same cycle as an apply re-arms with the new value.
            if (we) begin
                sh_n   <= wr_n;
                sh_m   <= wr_m;
                busy_q <= 1'b1;
            end
        end
    end

    assign busy = busy_q;
    assign cen  = cen_q;
    assign cenb = cenb_q;

`ifdef TOAPLAN2_CEN_MEASURE_EN
    logic [MEAS_W-1:0] cnt_q, meas_q;
    logic              pulse_run;

    assign pulse_run = pulse && !pause && !sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            meas_q <= '0;
        end else if (meas_win) begin
            meas_q <= cnt_q;
            cnt_q  <= pulse_run ? MEAS_W'(1) : '0;
        end else if (pulse_run && (cnt_q != '1)) begin
            cnt_q  <= cnt_q + MEAS_W'(1);
        end
    end

    assign meas_cnt = meas_q;
`endif

endmodule

// File: rtl/toaplan2_cen_bank.sv
// Multi-channel fractional clock-enable bank (CLK*n/m per channel, + /2 stages).
// Latency: enables are registered, one CLK after each channel's decision.
// Backpressure: none; PAUSE silences all channels, SYNC re-phases them.
//
// Ports: CLK, RESET (sync, active-high), PAUSE, SYNC, cfg_we/cfg_ch/cfg_n/
// cfg_m (runtime ratio write, cfg_ch >= NCH ignored), cfg_busy[NCH],
// cen[NCH*DIVS] (bit ch*DIVS+k), cenb[NCH].
// Optional macro TOAPLAN2_CEN_MEASURE_EN adds meas_win and meas_cnt[NCH*16].
module toaplan2_cen_bank
    import toaplan2_cen_pkg::*;
#(
    parameter int                NCH    = 2,
    parameter int                W      = 8,
    parameter int                DIVS   = 4,
    parameter logic [NCH*W-1:0]  N_INIT = {8'd8, 8'd1},
    parameter logic [NCH*W-1:0]  M_INIT = {8'd189, 8'd7}
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   PAUSE,
    input  logic                   SYNC,
    input  logic                   cfg_we,
    input  logic [2:0]             cfg_ch,
    input  logic [W-1:0]           cfg_n,
    input  logic [W-1:0]           cfg_m,
    output logic [NCH-1:0]         cfg_busy,
    output logic [NCH*DIVS-1:0]    cen,
    output logic [NCH-1:0]         cenb
`ifdef TOAPLAN2_CEN_MEASURE_EN
    ,
    input  logic                   meas_win,
    output logic [NCH*MEAS_W-1:0]  meas_cnt
`endif
);

    for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
        logic we_ch;
        assign we_ch = cfg_we && (cfg_ch == 3'(ch));

        toaplan2_cen_chan #(
            .W     (W),
            .DIVS  (DIVS),
            .N_RST (N_INIT[ch*W +: W]),
            .M_RST (M_INIT[ch*W +: W])
        ) u_chan (
            .clk      (CLK),
            .reset    (RESET),
            .pause    (PAUSE),
            .sync     (SYNC),
            .we       (we_ch),
            .wr_n     (cfg_n),
            .wr_m     (cfg_m),
            .busy     (cfg_busy[ch]),
            .cen      (cen[CEN_IDX(ch, 0, DIVS) +: DIVS]),
            .cenb     (cenb[ch])
`ifdef TOAPLAN2_CEN_MEASURE_EN
            ,
            .meas_win (meas_win),
            .meas_cnt (meas_cnt[ch*MEAS_W +: MEAS_W])
`endif
        );
    end

endmodule

// File: tb/tb_toaplan2_cen_bank.sv
module tb_toaplan2_cen_bank;
    import toaplan2_cen_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, pause = 1'b0, sync = 1'b0, we = 1'b0;
    logic [2:0] wch = '0;
    logic [7:0] wn = '0, wm = '0;
    logic [1:0] busy;
    logic [7:0] cen;
    logic [1:0] cenb;
`ifdef TOAPLAN2_CEN_MEASURE_EN
    logic        meas_win = 1'b0;
    logic [31:0] meas_cnt;
`endif

    toaplan2_cen_bank #(
        .NCH(2), .W(8), .DIVS(4),
        .N_INIT({8'd8, 8'd1}), .M_INIT({8'd189, 8'd7})
    ) dut (
        .CLK(clk), .RESET(rst), .PAUSE(pause), .SYNC(sync),
        .cfg_we(we), .cfg_ch(wch), .cfg_n(wn), .cfg_m(wm),
        .cfg_busy(busy), .cen(cen), .cenb(cenb)
`ifdef TOAPLAN2_CEN_MEASURE_EN
        , .meas_win(meas_win), .meas_cnt(meas_cnt)
`endif
    );

    int n_tests = 0, n_fail = 0;
    int tcount = 0;
    logic [11:0] cur;             // {busy[1:0], cenb[1:0], cen[7:0]}
    logic [11:0] sb_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (tick %0d)", tag, obs, exp, tcount);
        end
    endtask

    // Reference model of the two channels.
    int md_acc[2], md_n[2], md_m[2], md_sn[2], md_sm[2], md_busy[2], md_div[2];
    int ninit[2], minit[2];
    int s, a;
    bit p;

    task model_step(output logic [11:0] e);
        e = '0;
        ninit[0] = int'(R_1350_OF_945.n); minit[0] = int'(R_1350_OF_945.m);
        ninit[1] = int'(R_4_OF_945.n);    minit[1] = int'(R_4_OF_945.m);
        for (int c = 0; c < 2; c++) begin
            p = 0;
            if (rst) begin
                md_acc[c] = 0; md_div[c] = 0; md_busy[c] = 0;
                md_n[c] = ninit[c]; md_m[c] = minit[c];
                md_sn[c] = 0; md_sm[c] = 0;
            end else begin
                if (sync) begin
                    md_acc[c] = 0; md_div[c] = 0;
                    if (md_busy[c] != 0) begin
                        md_n[c] = md_sn[c]; md_m[c] = md_sm[c]; md_busy[c] = 0;
                    end
                end else if (pause) begin
                    if (md_busy[c] != 0 && md_m[c] == 0) begin
                        md_n[c] = md_sn[c]; md_m[c] = md_sm[c]; md_busy[c] = 0;
                    end
                end else if (md_m[c] == 0) begin
                    md_acc[c] = 0;
                    if (md_busy[c] != 0) begin
                        md_n[c] = md_sn[c]; md_m[c] = md_sm[c]; md_busy[c] = 0;
                    end
                end else begin
                    s = md_acc[c] + md_n[c];
                    if (md_n[c] >= md_m[c]) begin p = 1; a = 0; end
                    else if (s >= md_m[c]) begin p = 1; a = s - md_m[c]; end
                    else a = s;
                    if (!p && md_acc[c] < md_m[c] / 2 && s >= md_m[c] / 2) e[8+c] = 1'b1;
                    if (p) begin
                        for (int k = 0; k < 4; k++)
                            if (md_div[c] % (1 << k) == 0) e[c*4+k] = 1'b1;
                        md_div[c] = (md_div[c] + 1) % 8;
                    end
                    md_acc[c] = a;
                    if (p && md_busy[c] != 0) begin
                        md_n[c] = md_sn[c]; md_m[c] = md_sm[c]; md_busy[c] = 0;
                        if (md_acc[c] >= md_m[c]) md_acc[c] = 0;
                    end
                end
                if (we && int'(wch) == c) begin
                    md_sn[c] = int'(wn); md_sm[c] = int'(wm); md_busy[c] = 1;
                end
            end
            e[10+c] = (md_busy[c] != 0);
        end
    endtask

    // One clock: predict, clock, sample #1 later, compare against scoreboard.
    task tick();
        logic [11:0] e;
        model_step(e);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        cur = {busy, cenb, cen};
        tcount++;
        chk("cycle", cur, sb_q.pop_front());
    endtask

    int c[4], last[4], first0, badp[4];
    int c1, last1, gap1max, cbbad, cbcnt, quiet, f0, f1, lastc, t0, ones, cb1;
    bit found;

    initial begin
        repeat (3) tick();
        chk("reset_out", cur, 12'h000);
        rst = 1'b0;

        // Free run at reset ratios: 1890 cycles.
        for (int k = 0; k < 4; k++) begin c[k] = 0; last[k] = 0; badp[k] = 0; end
        c1 = 0; last1 = 0; gap1max = 0; cbbad = 0; cbcnt = 0; first0 = 0;
        for (int i = 1; i <= 1890; i++) begin
            tick();
            if (cur[8]) begin
                cbcnt++;
                if (cur[0] || (i - last[0]) != 3) cbbad++;
            end
            for (int k = 0; k < 4; k++) if (cur[k]) begin
                c[k]++;
                if (last[k] != 0 && (i - last[k]) != (7 << k)) badp[k]++;
                if (k == 0 && first0 == 0) first0 = i;
                last[k] = i;
            end
            if (cur[4]) begin
                if (i - last1 > gap1max) gap1max = i - last1;
                c1++; last1 = i;
            end
        end
        chk("ch0_first", first0, 7);
        chk("ch0_s0_cnt", c[0], 270);
        chk("ch0_s1_cnt", c[1], 135);
        chk("ch0_s2_cnt_pm1", (c[2] >= 66 && c[2] <= 68), 1);
        chk("ch0_s3_cnt_pm1", (c[3] >= 32 && c[3] <= 34), 1);
        for (int k = 0; k < 4; k++) chk("ch0_period_err", badp[k], 0);
        chk("ch1_s0_cnt", c1, 80);
        chk("ch1_gap_le24", (gap1max <= 24), 1);
        chk("ch0_cenb_phase", cbbad, 0);
        chk("ch0_cenb_cnt", cbcnt, 270);

        // Invalid channel writes are ignored.
        we = 1'b1; wch = 3'd5; wn = 8'd3; wm = 8'd4;
        tick();
        we = 1'b0;
        tick();
        chk("bad_ch_busy", cur[11:10], 2'b00);

        // PAUSE 20 cycles, SYNC under PAUSE, then release.
        pause = 1'b1;
        quiet = 0;
        repeat (20) begin tick(); if (cur[9:0] != 0) quiet++; end
        chk("pause_quiet", quiet, 0);
        sync = 1'b1;
        tick();
        chk("sync_quiet", cur[9:0], 10'h000);
        sync = 1'b0; pause = 1'b0;
        f0 = 0; f1 = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (cur[0] && f0 == 0) f0 = i;
            if (cur[4] && f1 == 0) f1 = i;
        end
        chk("sync_ch0_first", f0, 7);
        chk("sync_ch1_first", f1, 24);

        // Reprogram ch0 to 2/7 mid-period.
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin tick(); if (cur[0]) found = 1; end
        chk("wait_cen0", found, 1);
        lastc = tcount;
        tick(); tick();
        we = 1'b1; wch = 3'd0; wn = 8'd2; wm = 8'd7;
        tick();
        we = 1'b0;
        chk("busy_rise", cur[10], 1'b1);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin tick(); if (cur[0]) found = 1; end
        chk("old_gap", tcount - lastc, 7);
        chk("busy_clr_at_cen", cur[10], 1'b0);
        for (int g = 0; g < 3; g++) begin
            lastc = tcount; found = 0;
            for (int i = 0; i < 10 && !found; i++) begin tick(); if (cur[0]) found = 1; end
            chk("new_gap", tcount - lastc, (g % 2 == 0) ? 4 : 3);
        end

        // ch1: disable via m=0, then 1/1.
        we = 1'b1; wch = 3'd1; wn = 8'd8; wm = 8'd0;
        tick();
        we = 1'b0;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin tick(); if (!cur[11]) found = 1; end
        chk("m0_applied", found, 1);
        quiet = 0;
        repeat (30) begin tick(); if (cur[4] || cur[9]) quiet++; end
        chk("ch1_silent", quiet, 0);
        we = 1'b1; wch = 3'd1; wn = 8'd1; wm = 8'd1;
        tick();
        we = 1'b0;
        chk("dis_busy_set", cur[11], 1'b1);
        tick();
        chk("dis_busy_clr", cur[11], 1'b0);
        ones = 0; cb1 = 0;
        repeat (10) begin tick(); if (cur[4]) ones++; if (cur[9]) cb1++; end
        chk("ch1_every_cycle", ones, 10);
        chk("ch1_no_cenb", cb1, 0);

        // Reset discards a pending shadow.
        we = 1'b1; wch = 3'd0; wn = 8'd1; wm = 8'd9;
        tick();
        we = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_drop_shadow", cur, 12'h000);
        t0 = 0;
        for (int i = 1; i <= 10; i++) begin tick(); if (cur[0] && t0 == 0) t0 = i; end
        chk("rst_ratio_back", t0, 7);

`ifdef TOAPLAN2_CEN_MEASURE_EN
        meas_win = 1'b1; tick(); meas_win = 1'b0;
        repeat (699) tick();
        meas_win = 1'b1; tick(); meas_win = 1'b0;
        chk("meas_ch0", meas_cnt[15:0], 16'd100);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
